// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp constants for the highway/farm-road traffic controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_HG   = 3'd1,
        S_HY   = 3'd2,
        S_FG   = 3'd3,
        S_FY   = 3'd4
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // {hwy, farm} lamp pair for a state; anything not green/yellow on one road is red on both.
    function automatic logic [3:0] lamp_pair(input state_t s);
        case (s)
            S_HG:    lamp_pair = {LAMP_GREEN,  LAMP_RED};
            S_HY:    lamp_pair = {LAMP_YELLOW, LAMP_RED};
            S_FG:    lamp_pair = {LAMP_RED,    LAMP_GREEN};
            S_FY:    lamp_pair = {LAMP_RED,    LAMP_YELLOW};
            default: lamp_pair = {LAMP_RED,    LAMP_RED};
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_controller.sv
// Highway/farm-road traffic light FSM driving an external long/short timer.
// Optional pedestrian request input is compiled in with macro PED_REQ_EN.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int FARM_EXTEND_MAX = 2
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef PED_REQ_EN
    input  logic       ped_req,
`endif
    input  logic       car_farm,
    input  logic       Timer_done,
    output logic       Start_LongTimer,
    output logic       Start_ShortTimer,
    output logic [1:0] hwy_light,
    output logic [1:0] farm_light
);

    localparam int EXT_W = (FARM_EXTEND_MAX > 0) ? $clog2(FARM_EXTEND_MAX + 1) : 1;
    localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(FARM_EXTEND_MAX);

    state_t           state;
    logic             armed;
    logic [EXT_W-1:0] ext_cnt;
    logic             farm_req;
    logic             expire;

    // A Timer_done left over from the previous period is ignored until the new start has been seen.
    assign expire = armed & Timer_done & ~Start_LongTimer & ~Start_ShortTimer;

`ifdef PED_REQ_EN
    logic ped_latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ped_latch <= 1'b0;
        else if (ped_req)
            ped_latch <= 1'b1;
        else if (state == S_HY && expire)
            ped_latch <= 1'b0;
    end

    assign farm_req = car_farm | ped_latch;
`else
    assign farm_req = car_farm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= S_INIT;
            armed                  <= 1'b0;
            ext_cnt                <= '0;
            Start_LongTimer        <= 1'b0;
            Start_ShortTimer       <= 1'b0;
            {hwy_light, farm_light} <= {LAMP_RED, LAMP_RED};
        end else begin
            Start_LongTimer  <= 1'b0;
            Start_ShortTimer <= 1'b0;
            armed            <= 1'b1;
            case (state)
                S_INIT: begin
                    state                   <= S_HG;
                    Start_LongTimer         <= 1'b1;
                    armed                   <= 1'b0;
                    {hwy_light, farm_light} <= lamp_pair(S_HG);
                end
                S_HG: if (expire) begin
                    armed <= 1'b0;
                    if (farm_req) begin
                        state                   <= S_HY;
                        Start_ShortTimer        <= 1'b1;
                        {hwy_light, farm_light} <= lamp_pair(S_HY);
                    end else begin
                        Start_LongTimer <= 1'b1;
                    end
                end
                S_HY: if (expire) begin
                    armed                   <= 1'b0;
                    state                   <= S_FG;
                    Start_LongTimer         <= 1'b1;
                    ext_cnt                 <= '0;
                    {hwy_light, farm_light} <= lamp_pair(S_FG);
                end
                S_FG: if (expire) begin
                    armed <= 1'b0;
                    if (car_farm && ext_cnt < EXT_MAX) begin
                        ext_cnt         <= ext_cnt + 1'b1;
                        Start_LongTimer <= 1'b1;
                    end else begin
                        state                   <= S_FY;
                        Start_ShortTimer        <= 1'b1;
                        {hwy_light, farm_light} <= lamp_pair(S_FY);
                    end
                end
                S_FY: if (expire) begin
                    armed                   <= 1'b0;
                    state                   <= S_HG;
                    Start_LongTimer         <= 1'b1;
                    {hwy_light, farm_light} <= lamp_pair(S_HG);
                end
                default: begin
                    state                   <= S_INIT;
                    armed                   <= 1'b0;
                    ext_cnt                 <= '0;
                    {hwy_light, farm_light} <= {LAMP_RED, LAMP_RED};
                end
            endcase
        end
    end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 SHALL have parameter: FARM_EXTEND_MAX, default 2, max extra long-timer periods of farm green while a farm car is present (0 = no extension).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port: car_farm  input  1  farm-road vehicle sensor, level.
REQ-005 SHALL have port: Timer_done  input  1  expiry flag from timing block; stays high until the next start is sampled.
REQ-006 SHALL have port: Start_LongTimer  output  1  one-cycle request for the 25 s period.
REQ-007 SHALL have port: Start_ShortTimer  output  1  one-cycle request for the 4 s period.
REQ-008 SHALL have port: hwy_light  output  2  highway lamp: 00 red, 01 yellow, 10 green.
REQ-009 SHALL have port: farm_light  output  2  farm lamp, same encoding.
REQ-010 SHALL have port (PED_REQ_EN only): ped_req  input  1  pedestrian crossing button, pulse or level.

Function
REQ-011 SHALL implement states S_INIT, S_HG (hwy green/farm red), S_HY (hwy yellow/farm red), S_FG (hwy red/farm green), S_FY (hwy red/farm yellow).
REQ-012 SHALL register all outputs; lamps change on the same edge as the state.
REQ-013 SHALL leave S_INIT on the first edge after reset release -> S_HG, Start_LongTimer=1 for one cycle.
REQ-014 SHALL hold an armed flag: cleared on any edge that asserts a start output, set on the following edge; Timer_done is acted on only when armed=1 and both start outputs are 0.
REQ-015 SHALL treat an expiry (armed and Timer_done) as follows; no other event changes state:
- S_HG: farm request -> S_HY + Start_ShortTimer; else stay + Start_LongTimer.
- S_HY: -> S_FG + Start_LongTimer, ext_cnt<=0.
- S_FG: car_farm and ext_cnt<FARM_EXTEND_MAX -> stay, ext_cnt+1, Start_LongTimer; else -> S_FY + Start_ShortTimer.
- S_FY: -> S_HG + Start_LongTimer.
REQ-016 SHALL define farm request = car_farm sampled at the expiry edge (OR ped latch when PED_REQ_EN).
REQ-017 SHALL never assert Start_LongTimer and Start_ShortTimer in the same cycle; each start is exactly one cycle wide.
REQ-018 SHALL size ext_cnt as $clog2(FARM_EXTEND_MAX+1) bits (min 1); ext_cnt saturates, never wraps.
REQ-019 SHALL never drive green or yellow on both roads simultaneously; any illegal state encoding recovers to S_INIT.

Reset
REQ-020 SHALL on rst_n=0, immediately and asynchronously: state S_INIT, hwy_light=farm_light=00 (all red), both starts 0, armed 0, ext_cnt 0, ped latch 0.
REQ-021 SHALL behave, on reset asserted mid-sequence, identically to power-on reset; an in-flight Timer_done is ignored until the re-issued start is armed.

Configuration
REQ-022 SHALL compile ped_req and its latch only when macro PED_REQ_EN is defined: latch set by ped_req=1 on any edge, cleared on the edge entering S_FG; set wins over clear in the same cycle.
REQ-023 SHALL, without PED_REQ_EN, have no ped_req port and a farm request derived from car_farm only.

Structure
REQ-024 SHALL place the state enum and lamp constants (LAMP_RED, LAMP_YELLOW, LAMP_GREEN) in shared package traffic_pkg.
REQ-025 SHALL be a single module with no sub-module; the timing block is a peer at top level.

Verification
REQ-026 SHALL cover: reset release, car_farm=0 -> Start_LongTimer pulse on cycle 1, hwy=10 farm=00; each timer-model expiry -> another Start_LongTimer, state stays S_HG.
REQ-027 SHALL cover: car_farm=1 held, FARM_EXTEND_MAX=2 -> S_HY (Short), S_FG (Long), 2 further Long pulses in S_FG, then S_FY (Short), then S_HG (Long).
REQ-028 SHALL cover: Timer_done held high through the start cycle -> no transition until the model drops and re-raises it.
REQ-029 SHALL cover: rst_n low for 1 ns mid-S_FG -> lamps 00/00 and starts 0 without a clock edge; restart as in REQ-026.
REQ-030 SHALL cover: PED_REQ_EN, one-cycle ped_req in S_HG with car_farm=0 -> S_HY at next expiry; without the macro, build has no ped_req and stays S_HG.
